mult_server: RTL
================

Name: mult_server

Overview:
- Shared fixed-point multiplier responder serving NCLI client initiators, for example the lt_inverse datapath and its sibling matrix blocks.
- Each cycle it arbitrates one client request round-robin, accepts that client's operand pair and pushes it through a LAT-stage multiply pipeline.
- It returns the saturated Q-format product tagged with the requesting client's id.
- It honours the system-wide en freeze, so all clients sharing it stay cycle-aligned with their schedule counters.

Parameters:
- WIDTH, 27: signed operand and result width.
- FRAC, 16: fractional bits of the Q format (1.0 = 65536).
- NCLI, 2: number of client ports (2 to 8).
- LAT, 4: pipeline latency in enabled cycles, from accept to result (1 to 8).
- ID_W, $clog2(NCLI) (minimum 1): width of the client id tag.

Ports:
- clk, in, 1: system clock; all state updates on posedge.
- rst, in, 1: asynchronous reset, active-high.
- en, in, 1: global enable; 0 freezes all state and outputs.
- req, in, NCLI: req[i]=1 means client i presents an operand pair.
- dataa, in, NCLI*WIDTH: packed signed operand A; client i occupies bits [i*WIDTH +: WIDTH].
- datab, in, NCLI*WIDTH: packed signed operand B, same packing as dataa.
- grant, out, NCLI: one-hot; grant[i]=1 means client i's operands are accepted this cycle.
- result, out, WIDTH: signed saturated product.
- result_valid, out, 1: result and result_id are valid this cycle.
- result_id, out, ID_W: client index that issued the product.
- pending, out, 4: number of accepted operations not yet returned (0 to LAT).

Behaviour:
Reset:
- rst=1 asynchronously clears all pipeline valid bits and data, result=0, result_valid=0, result_id=0, pending=0.
- Round-robin pointer resets to 0, so client 0 has highest priority.
- grant is combinational and is 0 while rst=1.
- Reset during an operation discards every in-flight operation; no result is emitted for them after reset deasserts.

Arbitration:
- grant is combinational from req, the pointer, en and rst.
- With en=1, the first requesting client at or after the pointer, searching upward with wrap from NCLI-1 to 0, is granted.
- At most one grant per cycle; no grant when en=0 or req=0.
- On a grant to client k, the pointer becomes (k+1) mod NCLI at the clock edge. With no grant, the pointer holds.
- A client holds req and its operands until it sees grant. Operands are sampled on the edge where grant=1.

Pipeline:
- Stage 1 registers valid, id, A and B.
- The remaining LAT-1 stages carry the full 2*WIDTH signed product.
- The final stage drives result, result_valid and result_id as registered outputs.
- result_valid is asserted exactly LAT enabled edges after the accepting edge.
- One accept per cycle with back-to-back results; there is no bubble between consecutive accepts.

Arithmetic:
- Product P = A*B, full-precision signed 2*WIDTH bits.
- Arithmetic shift right by FRAC, truncating toward negative infinity.
- Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- result holds its last value when result_valid=0. Checkers must only compare it when result_valid=1.

pending counter:
- +1 on an accept, -1 on a result emission, unchanged when both occur in the same enabled cycle.
- Never exceeds LAT.

en=0:
- No grant; the pointer, all stages, outputs and pending hold their values.
- result_valid stays at its prior level; the consumer qualifies it with en, as the codebase counters do.

Test Plan:
- Reset, then client 0 requests A=98304 (1.5), B=131072 (2.0) with en=1 -> grant[0] in the same cycle; after 4 edges, result=196608, result_valid=1, result_id=0, pending back to 0.
- Client 1 requests A=-98304, B=131072 -> result=-196608 (0x7FD0000 in 27-bit two's complement), result_id=1. Also A=-1, B=1 -> result=-1 (floor behaviour).
- A=B=33554432 (512.0) -> result=67108863 saturated. A=33554432, B=-33554432 -> result=-67108864.
- Both clients hold req for 6 cycles with distinct operands -> grants 0,1,0,1,0,1; results return in the same order with matching ids on consecutive cycles; pending peaks at 4.
- Accept one op, drop en for 3 cycles after 2 edges -> no grant while en=0, outputs frozen; result appears on the 4th enabled edge, so 7 clocks after the accept.
- Accept 3 ops, assert rst asynchronously mid-cycle -> outputs clear immediately, pending=0; no result_valid in the 8 cycles after release; the next request goes to client 0 when both request.

Source files
------------

// File: rtl/mult_server.sv
// Purpose: shared signed Q-format multiplier; round-robin arbitration over NCLI client ports.
// Latency: LAT enabled edges from the accepting edge to result_valid; one accept per cycle.
// Backpressure: clients hold req and operands until grant; en=0 freezes everything.
// Ports: clk/rst (async, active-high), en (global freeze), req/dataa/datab (packed per client),
//        grant (one-hot, combinational), result/result_valid/result_id (registered),
//        pending (accepted operations whose result has not yet left the output stage).
module mult_server #(
  parameter int WIDTH = 27,
  parameter int FRAC  = 16,
  parameter int NCLI  = 2,
  parameter int LAT   = 4,
  parameter int ID_W  = (NCLI > 1) ? $clog2(NCLI) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NCLI-1:0]         req,
  input  logic [NCLI*WIDTH-1:0]   dataa,
  input  logic [NCLI*WIDTH-1:0]   datab,
  output logic [NCLI-1:0]         grant,
  output logic [WIDTH-1:0]        result,
  output logic                    result_valid,
  output logic [ID_W-1:0]         result_id,
  output logic [3:0]              pending
);

  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] SAT_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  // ---------------- arbitration ----------------
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] idx;
  logic            acc;
  logic signed [WIDTH-1:0] sel_a, sel_b;

  always_comb begin
    grant  = '0;
    gnt_id = '0;
    idx    = '0;
    acc    = 1'b0;
    if (en && !rst) begin
      // First requester at or above the pointer, wrapping past NCLI-1.
      for (int i = 0; i < NCLI; i++) begin
        idx = ID_W'((int'(ptr_q) + i) % NCLI);
        if (!acc && req[idx]) begin
          acc    = 1'b1;
          gnt_id = idx;
        end
      end
      if (acc) grant[gnt_id] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (acc) ptr_d = (gnt_id == ID_W'(NCLI - 1)) ? '0 : gnt_id + 1'b1;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NCLI; i++) begin
      if (gnt_id == ID_W'(i)) begin
        sel_a = dataa[i*WIDTH +: WIDTH];
        sel_b = datab[i*WIDTH +: WIDTH];
      end
    end
  end

  // ---------------- valid / id chain (element LAT-1 is the output stage) ----------------
  logic [LAT-1:0]            vld_q, vld_d;
  logic [LAT-1:0][ID_W-1:0]  id_q, id_d;
  logic [3:0]                pending_q, pending_d;

  always_comb begin
    vld_d     = vld_q;
    id_d      = id_q;
    pending_d = pending_q;
    if (en) begin
      vld_d     = LAT'({vld_q, acc});
      id_d      = (LAT*ID_W)'({id_q, gnt_id});
      // A result is counted out at the edge that ends its presentation cycle.
      pending_d = pending_q + {3'b000, acc} - {3'b000, vld_q[LAT-1]};
    end
  end

  // ---------------- datapath ----------------
  logic signed [PW-1:0] fin_prod;  // product feeding the output stage
  logic                 fin_vld;   // output stage loads a new result this edge

  generate
    if (LAT == 1) begin : g_lat1
      assign fin_prod = sel_a * sel_b;
      assign fin_vld  = acc;
    end else begin : g_ops
      logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d;
      logic signed [PW-1:0]    mult;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (acc) begin
          a_d = sel_a;
          b_d = sel_b;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end

      assign mult    = a_q * b_q;
      assign fin_vld = en && vld_q[LAT-2];

      if (LAT == 2) begin : g_noprod
        assign fin_prod = mult;
      end else begin : g_prod
        logic signed [PW-1:0] prod_q [LAT-2];
        logic signed [PW-1:0] prod_d [LAT-2];

        always_comb begin
          prod_d = prod_q;
          if (en) begin
            prod_d[0] = mult;
            for (int i = 1; i < LAT-2; i++) prod_d[i] = prod_q[i-1];
          end
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int i = 0; i < LAT-2; i++) prod_q[i] <= '0;
          end else begin
            prod_q <= prod_d;
          end
        end

        assign fin_prod = prod_q[LAT-3];
      end
    end
  endgenerate

  // ---------------- output stage: floor shift, then saturate ----------------
  logic signed [PW-1:0] shifted;
  logic [WIDTH-1:0]     result_q, result_d;

  always_comb begin
    shifted  = fin_prod >>> FRAC;
    result_d = result_q;
    if (fin_vld) begin
      if (shifted > SAT_MAX)      result_d = SAT_MAX[WIDTH-1:0];
      else if (shifted < SAT_MIN) result_d = SAT_MIN[WIDTH-1:0];
      else                        result_d = shifted[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      vld_q     <= '0;
      id_q      <= '0;
      pending_q <= '0;
      result_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      vld_q     <= vld_d;
      id_q      <= id_d;
      pending_q <= pending_d;
      result_q  <= result_d;
    end
  end

  assign result       = result_q;
  assign result_valid = vld_q[LAT-1];
  assign result_id    = id_q[LAT-1];
  assign pending      = pending_q;

endmodule
